// File: rtl/down_timer_pkg.sv
// Shared types and helpers for the loadable countdown timer.
package down_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HOLD    = 2'd2,
      EXPIRED = 2'd3
   } state_e;

   // Prescaler counter width; a PRESCALE of 1 still gets a 1-bit counter.
   function automatic int presc_width(input int prescale);
      return (prescale <= 2) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/down_timer_tick_prescaler.sv
// Divides enabled clock cycles down to one tick every PRESCALE enabled cycles.
module tick_prescaler
   import down_timer_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int PW = presc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;

   assign tick = enable & (presc_q == LAST);

   always_comb begin
      presc_d = presc_q;
      if (clear || tick) begin
         presc_d = '0;
      end else if (enable) begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/down_timer.sv
// Loadable countdown timer with pause, abort and expiry flag.
// Define DOWN_TIMER_AUTO_RELOAD_EN for periodic mode (reload from last accepted load).
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             enable,
   input  logic             abort,
   output logic [WIDTH-1:0] count_out,
   output logic             busy,
   output logic             done,
   output logic             expired
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             expired_q, expired_d;

   logic load_acc;
   logic start_acc;
   logic presc_clear;
   logic presc_en;
   logic tick;

   assign load_ready  = ((state_q == IDLE) || (state_q == EXPIRED)) && !reset;
   assign load_acc    = load_valid & load_ready & ~abort;
   assign start_acc   = (state_q == IDLE) & start & ~abort & ~load_acc;
   assign presc_clear = abort | load_acc | start_acc;
   assign presc_en    = (state_q == RUN) & enable;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (presc_clear),
      .enable (presc_en),
      .tick   (tick)
   );

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;

   always_comb begin
      reload_d = load_acc ? load_value : reload_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else if (load_acc) begin
         count_d = load_value;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (count_q == '0) begin
                     state_d = EXPIRED;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (!enable) begin
                  state_d = HOLD;
               end else if (tick) begin
                  if (count_q > ONE) begin
                     count_d = count_q - ONE;
                  end else begin
                     // Count of 1 (or a stray 0) expires rather than wrapping.
                     done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                     if (reload_q != '0) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = EXPIRED;
                     end
`else
                     count_d = '0;
                     state_d = EXPIRED;
`endif
                  end
               end
            end
            HOLD: begin
               if (enable) begin
                  state_d = RUN;
               end
            end
            default: begin
            end
         endcase
      end
      busy_d    = (state_d == RUN) || (state_d == HOLD);
      expired_d = (state_d == EXPIRED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         expired_q <= expired_d;
      end
   end

   assign count_out = count_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign expired   = expired_q;

endmodule
